// File: rtl/uart_tx_ser_pkg.sv
// Shared UART definitions: baud divisors for a 12 MHz clock, parity codes and FSM states.
// The RX side imports the same package.
package uart_tx_ser_pkg;

    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B38400  = 313;
    localparam int unsigned B19200  = 625;
    localparam int unsigned B9600   = 1250;
    localparam int unsigned B4800   = 2500;
    localparam int unsigned B2400   = 5000;
    localparam int unsigned B1200   = 10000;
    localparam int unsigned B600    = 20000;
    localparam int unsigned B300    = 40000;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StPar   = 3'd3,
        StStop  = 3'd4
    } uart_state_t;

endpackage

// File: rtl/baudgen_tx.sv
// Transmit baud tick generator: one-cycle pulse every BAUDRATE cycles while enabled,
// first pulse one cycle after enable rises.
module baudgen_tx
    import uart_tx_ser_pkg::*;
#(
    parameter int unsigned BAUDRATE = B9600
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int unsigned CW = (BAUDRATE > 2) ? $clog2(BAUDRATE) : 1;

    logic [CW-1:0] cnt;

    // Counter held at zero while disabled so every frame starts on the same phase.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (!clk_ena) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            clk_out <= (cnt == '0);
            cnt     <= (cnt == CW'(BAUDRATE - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: start/ready handshake in, one LSB-first frame out on tx
// (start, data, optional parity, stop bits), paced by baudgen_tx.
module uart_tx_ser
    import uart_tx_ser_pkg::*;
#(
    parameter int unsigned BAUDRATE  = B9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 tx
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        BAUDRATE < 2) begin : g_bad_param
        $error("uart_tx_ser: illegal parameter value");
    end

    localparam int unsigned CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS);

    uart_state_t         state;
    logic [DATA_BITS:0]  shreg;
    logic [CW-1:0]       bitcnt;
    logic                busy;
    logic                tick;
    logic                par_bit;

    assign busy = (state != StIdle);

    always_comb begin
        par_bit = (PARITY == PAR_ODD) ? ~^data : ^data;
    end

    baudgen_tx #(
        .BAUDRATE (BAUDRATE)
    ) u_baud (
        .rstn    (rstn),
        .clk     (clk),
        .clk_ena (busy),
        .clk_out (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= StIdle;
            tx     <= 1'b1;
            ready  <= 1'b1;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        shreg <= {par_bit, data};
                        state <= StStart;
                        ready <= 1'b0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        shreg <= {1'b1, shreg[DATA_BITS:1]};
                        if (bitcnt == LAST_DATA) begin
                            bitcnt <= '0;
                            state  <= (PARITY != PAR_NONE) ? StPar : StStop;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                StPar: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= StStop;
                    end
                end
                StStop: begin
                    // STOP_BITS ticks drive the stop bits; the one after ends the frame.
                    if (tick) begin
                        if (bitcnt == LAST_STOP) begin
                            bitcnt <= '0;
                            state  <= StIdle;
                            ready  <= 1'b1;
                        end else begin
                            tx     <= 1'b1;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: four instances (8N1, 8E1, 8O1, 8N2) at BAUDRATE=4,
// checked cycle by cycle against hand-built frames.
module tb_uart_tx_ser;

    localparam int B = 4;

    logic       clk;
    logic       rstn;
    logic       start_s [4];
    logic [7:0] data_s  [4];
    logic       ready_s [4];
    logic       tx_s    [4];

    int total = 0;
    int bad   = 0;

    uart_tx_ser #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rstn(rstn), .start(start_s[0]), .data(data_s[0]),
        .ready(ready_s[0]), .tx(tx_s[0]));
    uart_tx_ser #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rstn(rstn), .start(start_s[1]), .data(data_s[1]),
        .ready(ready_s[1]), .tx(tx_s[1]));
    uart_tx_ser #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d2 (
        .clk(clk), .rstn(rstn), .start(start_s[2]), .data(data_s[2]),
        .ready(ready_s[2]), .tx(tx_s[2]));
    uart_tx_ser #(.BAUDRATE(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d3 (
        .clk(clk), .rstn(rstn), .start(start_s[3]), .data(data_s[3]),
        .ready(ready_s[3]), .tx(tx_s[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic etx, input logic erdy);
        total++;
        assert ({tx_s[idx], ready_s[idx]} === {etx, erdy}) else begin
            bad++;
            $error("FAIL %s dut%0d: tx,ready got %b%b want %b%b", tag, idx, tx_s[idx],
                   ready_s[idx], etx, erdy);
        end
    endtask

    task automatic chk_tick(input string tag);
        total++;
        assert (u_d0.tick === 1'b0) else begin
            bad++;
            $error("FAIL %s: tick got %b want 0", tag, u_d0.tick);
        end
    endtask

    // Called one step into a cycle where ready=1; returns one step into the first ready
    // cycle after the frame (t+3+Nf*B).
    task automatic frame(input int idx, input logic [7:0] val, input int pe, input logic pb,
                         input int stops, input bit hold, input bit scramble,
                         input string tag);
        int          nf;
        int          last;
        logic [15:0] fb;
        logic        etx;
        nf   = 1 + 8 + pe + stops;
        last = 3 + nf * B;
        fb   = 16'hffff;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = val[i];
        if (pe != 0) fb[9] = pb;
        start_s[idx] = 1'b1;
        data_s[idx]  = val;
        step();
        if (!hold) start_s[idx] = 1'b0;
        chk({tag, "_t1"}, idx, 1'b1, 1'b0);
        for (int c = 2; c <= last; c++) begin
            if (scramble) begin
                data_s[idx]  = 8'($urandom);
                start_s[idx] = 1'b1;
            end
            step();
            etx = (c >= 3 && c < last) ? fb[(c - 3) / B] : 1'b1;
            chk(tag, idx, etx, c == last);
        end
        if (scramble) start_s[idx] = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            data_s[i]  = 8'h00;
        end
        step();

        // 1. reset while idle, then idle with no baud ticks
        rstn = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            for (int i = 0; i < 4; i++) chk("reset", i, 1'b1, 1'b1);
            chk_tick("reset_tick");
        end
        rstn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("idle", 0, 1'b1, 1'b1);
            chk_tick("idle_tick");
        end

        // 2. 0x55 at 8N1, ready back at t+43
        frame(0, 8'h55, 0, 1'b0, 1, 1'b0, 1'b0, "8n1_55");
        step();

        // 3. parity: even 0x07 -> 1, odd 0x07 -> 0; ready at t+47
        frame(1, 8'h07, 1, 1'b1, 1, 1'b0, 1'b0, "8e1_07");
        frame(2, 8'h07, 1, 1'b0, 1, 1'b0, 1'b0, "8o1_07");
        step();

        // 4. start and data toggled during the frame are ignored
        frame(0, 8'hAA, 0, 1'b0, 1, 1'b0, 1'b1, "scramble_aa");
        for (int n = 0; n < 3 * B; n++) begin
            step();
            chk("no_second", 0, 1'b1, 1'b1);
        end

        // 5. start held across two 8N2 frames: back-to-back acceptance
        frame(3, 8'h5A, 0, 1'b0, 2, 1'b1, 1'b0, "8n2_first");
        frame(3, 8'hC3, 0, 1'b0, 2, 1'b0, 1'b0, "8n2_second");
        step();
        chk("8n2_after", 3, 1'b1, 1'b1);

        // 6. reset during data bit 3 of 0x33, then a clean 0x0F frame
        start_s[0] = 1'b1;
        data_s[0]  = 8'h33;
        step();
        start_s[0] = 1'b0;
        for (int c = 2; c <= 3 + 4 * B + 1; c++) step();
        chk("mid_d3", 0, 1'b0, 1'b0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("mid_reset", 0, 1'b1, 1'b1);
        frame(0, 8'h0F, 0, 1'b0, 1, 1'b0, 1'b0, "after_reset_0f");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

endmodule
